// File: rtl/addseq_pkg.sv
// Shared definitions for the sequential adder arbiter: FSM encoding,
// datapath sizing and a small grant-decode helper.
package addseq_pkg;

  localparam int ADDSEQ_WIDTH = 32;
  localparam int ADDSEQ_NREQ  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One-hot ready mask for the granted requester of a 2-way arbiter.
  function automatic logic [1:0] grant_onehot(input logic id);
    if (id) begin
      grant_onehot = 2'b10;
    end else begin
      grant_onehot = 2'b01;
    end
  endfunction

endpackage

// File: rtl/alu_adder.sv
// Combinational WIDTH-bit adder with carry-in; the sum wraps modulo 2^WIDTH.
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_0,
  output logic [WIDTH-1:0] sum
);

  // Plain modular addition; the carry-out is not needed by this adder's users.
  always_comb begin
    sum = a + b + {{(WIDTH-1){1'b0}}, c_0};
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant decision is combinational; the
// priority pointer moves to the other requester when a grant is released.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       release_en,
  input  logic       release_id,
  output logic       gnt_id
);

  logic rr_ptr_r;

  // Priority pointer: favour the requester that was not served last.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_r <= 1'b0;
    end else if (release_en) begin
      rr_ptr_r <= ~release_id;
    end
  end

  // Grant decode: a lone requester wins outright, a tie goes to the pointer.
  always_comb begin
    gnt_id = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = rr_ptr_r;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/add_seq_arbiter.sv
// add_seq_arbiter: shares one 32-bit adder between two operand streams.
// A requester is granted round-robin per transaction, its operands are summed
// mod 2^32 and the result is handed over on a valid/ready interface.
// Optional feature macro: ADDSEQ_CARRY_EN adds a sticky carry-out flag on
// output res_carry.
module add_seq_arbiter
  import addseq_pkg::*;
#(
  parameter int WIDTH = ADDSEQ_WIDTH,
  parameter int NREQ  = ADDSEQ_NREQ,
  parameter int CNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic                  res_id,
  output logic [CNT_W-1:0]      res_count,
`ifdef ADDSEQ_CARRY_EN
  output logic                  res_carry,
`endif
  output logic                  busy
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               grant_r;
  logic               gnt_s;
  logic               release_en_s;
  logic [WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   sum_s;
  logic [WIDTH-1:0]   beat_data_s;
  logic               beat_last_s;
  logic               beat_hs_s;
  logic [NREQ-1:0]    req_ready_r;
  logic               busy_r;
  logic               res_valid_r;
  logic [WIDTH-1:0]   res_data_r;
  logic               res_id_r;
  logic [CNT_W-1:0]   res_count_r;
`ifdef ADDSEQ_CARRY_EN
  logic               carry_r;
  logic               carry_beat_s;
  logic               res_carry_r;
`endif

  // Operand counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      cnt_sat_inc = v;
    end else begin
      cnt_sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Only the granted requester's lane is ever looked at.
  assign beat_data_s  = grant_r ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
  assign beat_last_s  = req_last[grant_r];
  assign beat_hs_s    = req_valid[grant_r] & req_ready_r[grant_r];
  assign release_en_s = (state_r == ST_DONE) & res_ready;

  rr_arb2 u_arb (
    .clock      (clock),
    .reset      (reset),
    .req        (req_valid),
    .release_en (release_en_s),
    .release_id (grant_r),
    .gnt_id     (gnt_s)
  );

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (acc_r),
    .b   (beat_data_s),
    .c_0 (1'b0),
    .sum (sum_s)
  );

`ifdef ADDSEQ_CARRY_EN
  // A beat carried out of the top bit exactly when the wrapped sum is below the operand.
  assign carry_beat_s = (sum_s < beat_data_s);
`endif

  // Next-state decode for the transaction sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_nxt_s = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (beat_hs_s && beat_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered ready/busy derived from the upcoming state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      grant_r     <= 1'b0;
      req_ready_r <= {NREQ{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      if (state_nxt_s == ST_ACCUM) begin
        req_ready_r <= grant_onehot(grant_r);
      end else begin
        req_ready_r <= {NREQ{1'b0}};
      end
      if ((state_r == ST_IDLE) && (|req_valid)) begin
        grant_r <= gnt_s;
      end
    end
  end

  // Accumulator, operand count and result holding registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      res_valid_r <= 1'b0;
      res_data_r  <= {WIDTH{1'b0}};
      res_id_r    <= 1'b0;
      res_count_r <= {CNT_W{1'b0}};
`ifdef ADDSEQ_CARRY_EN
      carry_r     <= 1'b0;
      res_carry_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_GRANT: begin
          acc_r   <= {WIDTH{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
`ifdef ADDSEQ_CARRY_EN
          carry_r <= 1'b0;
`endif
        end
        ST_ACCUM: begin
          if (beat_hs_s) begin
            acc_r <= sum_s;
            cnt_r <= cnt_sat_inc(cnt_r);
`ifdef ADDSEQ_CARRY_EN
            carry_r <= carry_r | carry_beat_s;
`endif
            if (beat_last_s) begin
              res_valid_r <= 1'b1;
              res_data_r  <= sum_s;
              res_id_r    <= grant_r;
              res_count_r <= cnt_sat_inc(cnt_r);
`ifdef ADDSEQ_CARRY_EN
              res_carry_r <= carry_r | carry_beat_s;
`endif
            end
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_id    = res_id_r;
  assign res_count = res_count_r;
`ifdef ADDSEQ_CARRY_EN
  assign res_carry = res_carry_r;
`endif

endmodule
